// File: rtl/lcd_busy_reader.sv
// Read-side engine for an HD44780-style LCD bus: BF/AC or data-RAM read cycles,
// with an optional busy-flag poll loop bounded by POLL_MAX reads.
module lcd_busy_reader #(
    parameter int T_AS     = 2,
    parameter int T_EN     = 25,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 50,
    parameter int POLL_MAX = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       poll_mode,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       bus_release,
    output logic       active,
    output logic       rd_done,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout
);

    localparam int PH_A   = (T_AS > T_EN) ? T_AS : T_EN;
    localparam int PH_B   = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int CW     = $clog2(POLL_MAX + 1);

    localparam logic [PW-1:0] AS_LAST    = PW'(T_AS - 1);
    localparam logic [PW-1:0] EN_LAST    = PW'(T_EN - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(T_HOLD - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(T_GAP - 1);
    localparam logic [CW-1:0] POLL_LIMIT = CW'(POLL_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        GAP,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic [CW-1:0] poll_cnt;
    logic          rs_lat;
    logic          poll_lat;
    logic          rs_next;
    logic          poll_next;
    logic          accept;
    logic          sample;
    logic          set_timeout;
    logic          bus_own_next;

    always_comb begin
        next_state  = state;
        phase_next  = phase + 1'b1;
        rs_next     = rs_lat;
        poll_next   = poll_lat;
        accept      = 1'b0;
        sample      = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                phase_next = '0;
                if (rd_req) begin
                    next_state = SETUP;
                    accept     = 1'b1;
                    rs_next    = rd_rs;
                    poll_next  = poll_mode & ~rd_rs;
                end
            end
            SETUP: begin
                if (phase == AS_LAST) begin
                    next_state = EN_HI;
                    phase_next = '0;
                end
            end
            EN_HI: begin
                if (phase == EN_LAST) begin
                    next_state = HOLD;
                    phase_next = '0;
                    sample     = 1'b1;
                end
            end
            HOLD: begin
                // busy_flag already holds the value sampled at the end of EN_HI
                if (phase == HOLD_LAST) begin
                    phase_next = '0;
                    if (poll_lat && busy_flag) begin
                        if (poll_cnt < POLL_LIMIT) begin
                            next_state = GAP;
                        end else begin
                            next_state  = DONE;
                            set_timeout = 1'b1;
                        end
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    next_state = SETUP;
                    phase_next = '0;
                end
            end
            DONE: begin
                next_state = IDLE;
                phase_next = '0;
            end
            default: begin
                next_state = IDLE;
                phase_next = '0;
            end
        endcase
        bus_own_next = (next_state == SETUP) || (next_state == EN_HI) || (next_state == HOLD);
    end

    // Bus outputs are decoded from the next state so every pin comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            poll_cnt    <= '0;
            rs_lat      <= 1'b0;
            poll_lat    <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_en      <= 1'b0;
            bus_release <= 1'b0;
            active      <= 1'b0;
            rd_done     <= 1'b0;
            rd_data     <= '0;
            busy_flag   <= 1'b0;
            addr_cnt    <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= next_state;
            phase       <= phase_next;
            rs_lat      <= rs_next;
            poll_lat    <= poll_next;
            lcd_rs      <= bus_own_next & rs_next;
            lcd_rw      <= bus_own_next;
            bus_release <= bus_own_next;
            lcd_en      <= (next_state == EN_HI);
            active      <= (next_state != IDLE);
            rd_done     <= (next_state == DONE);
            if (accept) begin
                timeout  <= 1'b0;
                poll_cnt <= '0;
            end
            if (sample) begin
                rd_data <= lcd_data_in;
                if (!rs_lat) begin
                    busy_flag <= lcd_data_in[7];
                    addr_cnt  <= lcd_data_in[6:0];
                end
                if (poll_cnt != POLL_LIMIT) begin
                    poll_cnt <= poll_cnt + 1'b1;
                end
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/lcd_busy_reader.md
Name: lcd_busy_reader

Overview:
- Read-side engine for the HD44780-style character LCD bus. Performs RW=1 read cycles, either a busy-flag/address-counter read (RS=0) or a data-RAM read (RS=1), and returns the sampled byte.
- Optional poll mode repeats BF reads until the busy flag clears or a poll limit is hit. This lets the LCD display controller wait on the real busy flag instead of fixed delays.
- Sits beside the LCD write driver. Top-level muxes `lcd_rs`/`lcd_rw`/`lcd_en` and releases the data bus while `bus_release`=1.

Parameters:
- T_AS, 2: cycles RS/RW stable before EN rises (address setup).
- T_EN, 25: cycles EN held high; data sampled on the last of them (500 ns at 50 MHz).
- T_HOLD, 2: cycles EN low with RW still 1 after the fall.
- T_GAP, 50: idle cycles between successive poll reads.
- POLL_MAX, 2000: maximum reads in one poll request before timeout (≥1).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- rd_req, input, 1: start request; sampled only in IDLE.
- rd_rs, input, 1: 0 = BF/AC read, 1 = data read; latched with rd_req.
- poll_mode, input, 1: 1 = repeat BF reads until BF=0; latched with rd_req; ignored when rd_rs=1.
- lcd_data_in, input, 8: LCD DB7..DB0 as seen at the pad.
- lcd_rs, output, 1: LCD register select.
- lcd_rw, output, 1: LCD read/write, 1 = read.
- lcd_en, output, 1: LCD enable strobe.
- bus_release, output, 1: 1 while the reader owns the bus; writer must tristate DB.
- active, output, 1: 1 whenever the state is not IDLE.
- rd_done, output, 1: one-cycle pulse; result valid.
- rd_data, output, 8: last sampled byte.
- busy_flag, output, 1: DB7 of the last RS=0 read.
- addr_cnt, output, 7: DB6..DB0 of the last RS=0 read.
- timeout, output, 1: poll limit reached; held until next accepted rd_req.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: all outputs 0, including `lcd_rs`, `lcd_rw` and `lcd_en`. State IDLE, counters 0.
- States: IDLE, SETUP, EN_HI, HOLD, GAP, DONE.
- IDLE:
  - `rd_req`=1 at edge k latches `rd_rs` and `poll_mode`, clears `timeout` and the poll count, then goes to SETUP.
  - `rd_req` in any other state is ignored. It is not queued.
- SETUP (T_AS cycles): `lcd_rs`=latched rs, `lcd_rw`=1, `bus_release`=1, `lcd_en`=0.
- EN_HI (T_EN cycles):
  - `lcd_en`=1.
  - On the last cycle: `rd_data`<=`lcd_data_in`. If rs=0, also `busy_flag`<=DB7 and `addr_cnt`<=DB6..0. Poll count +1.
  - rs=1 reads leave `busy_flag` and `addr_cnt` unchanged.
- HOLD (T_HOLD cycles): `lcd_en`=0, `lcd_rw`=1, `bus_release`=1. At the end of HOLD:
  - If poll is active (poll_mode & rs=0), `busy_flag`=1 and poll count < POLL_MAX: go to GAP.
  - If poll is active, `busy_flag`=1 and poll count = POLL_MAX: set `timeout`=1 and go to DONE.
  - Otherwise: go to DONE.
- GAP (T_GAP cycles): `lcd_rw`=0, `bus_release`=0, `lcd_en`=0, then go to SETUP.
- DONE (1 cycle): `rd_done`=1, `lcd_rw`=0, `bus_release`=0, then go to IDLE. `rd_data`, `busy_flag`, `addr_cnt` and `timeout` stay stable until the next sample.
- Latency, single read with defaults: `rd_req` at edge k gives SETUP k+1..k+2, EN_HI k+3..k+27, HOLD k+28..k+29, `rd_done` at k+30. In general `rd_done` is at k+T_AS+T_EN+T_HOLD+1.
- Poll of n reads: `rd_done` at k + n·(T_AS+T_EN+T_HOLD) + (n−1)·T_GAP + 1.
- `lcd_en` never rises in the same cycle RS/RW change. RS/RW never change while `lcd_en`=1.
- Counters: phase counter wide enough for max(T_AS,T_EN,T_HOLD,T_GAP). Poll counter is clog2(POLL_MAX+1) bits and saturates, never wraps.
- Reset mid-operation (any state): the next edge forces IDLE and all outputs 0. `lcd_en` drops on that edge, no `rd_done` is produced, and sampled registers are cleared.
- `rd_req` and `rst` in the same cycle: reset wins and the request is lost.

Test Plan (small params allowed: T_AS=2, T_EN=4, T_HOLD=2, T_GAP=3, POLL_MAX=5 unless noted):
- Defaults; rd_req pulse (rs=0, poll=0) at edge 10; bus=0x25 → EN high for cycles 13..37, `rd_done` only at 40, `busy_flag`=0, `addr_cnt`=0x25, `rd_data`=0x25, `timeout`=0.
- rs=1, bus=0xA5, prior `addr_cnt`=0x25 → `rd_data`=0xA5, `lcd_rs`=1 throughout SETUP..HOLD, `busy_flag`/`addr_cnt` unchanged.
- Poll, bus=0x80 for first 3 samples then 0x10 → exactly 4 EN pulses, 3 GAPs with `lcd_rw`=0, `rd_done` once, `busy_flag`=0, `addr_cnt`=0x10, `timeout`=0.
- Poll, bus held 0xFF → exactly 5 EN pulses, `rd_done` once, `timeout`=1, `busy_flag`=1; next accepted rd_req clears `timeout`.
- `rst` asserted during EN_HI → next edge `lcd_en`=0, `lcd_rw`=0, `active`=0, `rd_data`=0; no `rd_done` ever follows.
- rd_req re-pulsed during SETUP and HOLD → ignored; one `rd_done`; EN pulse count unchanged; checker confirms RS/RW stable whenever `lcd_en`=1.
